synth_param_shadow: RTL and testbench
=====================================

// Module: synth_param_shadow
// PURPOSE
// - Synth-domain parameter bank for N_VOICES voices, one clock. Replaces flat
//   per-field buses with addressed writes into shadow registers.
// - Shadow contents copy to the active outputs atomically, only on a sample_tick.
// - Sits between the single-clock CDC/MMIO front end and the NCO/mixer datapath.
// PARAMETERS
// - N_VOICES     4   voice count (>=1)
// - FCW_WIDTH    24  carrier/mod frequency control word width
// - SHIFT_WIDTH  5   mod_shift / synth_shift width
// - ADDR_W       $clog2(N_VOICES+4)  write address width (derived; do not override)
// PORTS
// - clk             in   1                      synth clock
// - rst             in   1                      sync reset, active-high
// - wr_valid        in   1                      write request
// - wr_ready        out  1                      write accepted when wr_valid&wr_ready
// - wr_addr         in   ADDR_W                 register select (map below)
// - wr_data         in   FCW_WIDTH              write data, LSB-aligned
// - commit_req      in   1                      4-phase commit request
// - commit_ack      out  1                      4-phase commit acknowledge
// - sample_tick     in   1                      1-cycle strobe at audio sample rate
// - carrier_fcws    out  [N_VOICES-1:0][FCW_WIDTH-1:0]  active carrier FCWs
// - mod_fcw         out  FCW_WIDTH              active modulator FCW
// - mod_shift       out  SHIFT_WIDTH            active modulation shift
// - synth_shift     out  SHIFT_WIDTH            active output shift
// - note_en         out  N_VOICES               active per-voice enable
// - wr_err          out  1                      sticky: write to unmapped address
// BEHAVIOUR
// - Address map: 0..N_VOICES-1 carrier_fcw[i]; N_VOICES mod_fcw;
//   N_VOICES+1 mod_shift (wr_data[SHIFT_WIDTH-1:0]); N_VOICES+2 synth_shift;
//   N_VOICES+3 note_en (wr_data[N_VOICES-1:0]). Upper unused data bits ignored.
// - Unmapped addr: write accepted (handshake completes), data dropped, wr_err<=1.
// - Reset: all shadow and active regs 0, state IDLE, commit_ack 0, wr_err 0.
//   wr_ready = (state==IDLE) & ~rst, so 0 during rst, 1 the cycle after.
// - FSM: IDLE --commit_req--> PEND --sample_tick--> ACK --!commit_req--> IDLE.
//   IDLE: writes accepted, 1 per cycle, shadow updated at clock edge.
//   PEND: wr_ready=0 (shadow frozen); on sample_tick copy all shadow->active
//         in that edge, go ACK.
//   ACK: commit_ack=1 (registered); wr_ready=0; leave when commit_req low.
// - commit_ack: 1 only in ACK; falls cycle after commit_req seen low.
// - Same-cycle write + commit_req in IDLE: write lands, is included in commit.
// - sample_tick in cycle commit_req first seen (IDLE): ignored; commit on the
//   next tick. Active outputs change only on a PEND-state tick edge.
// - Latency: active valid 1 cycle after the tick edge in PEND; ack same edge.
// - commit_req held high after ACK->IDLE impossible (ACK waits for low).
// - rst mid-PEND/ACK: abandons commit, all regs to reset values.
// - Outputs are registers; no combinational path from inputs except wr_ready.
// CONFIGURATION
// - SYNTH_PARAM_READBACK_EN defined: adds ports rd_en in 1, rd_addr in ADDR_W,
//   rd_data out FCW_WIDTH. rd_data registered, 1-cycle latency, returns ACTIVE
//   value zero-extended; unmapped addr returns 0; rd_data resets to 0; holds
//   when rd_en=0. Reads never stall and ignore FSM state.
// - Undefined: no readback ports, no readback logic.
// TESTING
// - Reset: rst 2 cycles -> all outputs 0, wr_ready 0 during rst, 1 after.
// - Write addr0=0x123456, addr N_VOICES+3=0xF, no commit, 5 ticks -> outputs
//   stay 0; then req, tick -> carrier_fcws[0]=0x123456, note_en=4'hF, ack=1.
// - commit_req and sample_tick same first cycle -> no update; next tick
//   commits; ack drops 1 cycle after req low; wr_ready back to 1.
// - In PEND, wr_valid=1 addr1=0xABCDEF -> wr_ready=0, write not taken until
//   IDLE; after re-commit carrier_fcws[1]=0xABCDEF.
// - Write addr N_VOICES+4 (unmapped) -> accepted, wr_err=1 sticky, no reg change.
// - rst during PEND -> commit_ack stays 0, outputs 0, state IDLE afterwards.

Source files
------------

// File: rtl/synth_param_shadow.sv
// Parameter bank for the synth voices. Writes go into a shadow register bank, and the
// active outputs take the shadow contents only on a sample_tick after a commit request.
// Defining SYNTH_PARAM_READBACK_EN adds a registered read port that returns active values.
module synth_param_shadow #(
    parameter int N_VOICES    = 4,
    parameter int FCW_WIDTH   = 24,
    parameter int SHIFT_WIDTH = 5,
    localparam int ADDR_W     = $clog2(N_VOICES + 4)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_valid,
    output logic                                wr_ready,
    input  logic [ADDR_W-1:0]                   wr_addr,
    input  logic [FCW_WIDTH-1:0]                wr_data,
    input  logic                                commit_req,
    output logic                                commit_ack,
    input  logic                                sample_tick,
    output logic [N_VOICES-1:0][FCW_WIDTH-1:0]  carrier_fcws,
    output logic [FCW_WIDTH-1:0]                mod_fcw,
    output logic [SHIFT_WIDTH-1:0]              mod_shift,
    output logic [SHIFT_WIDTH-1:0]              synth_shift,
    output logic [N_VOICES-1:0]                 note_en,
`ifdef SYNTH_PARAM_READBACK_EN
    input  logic                                rd_en,
    input  logic [ADDR_W-1:0]                   rd_addr,
    output logic [FCW_WIDTH-1:0]                rd_data,
`endif
    output logic                                wr_err
);

    typedef enum logic [1:0] {IDLE, PEND, ACK} state_t;

    state_t                             state_q, state_d;
    logic                               ack_q, ack_d;
    logic                               wr_err_q, wr_err_d;
    logic [N_VOICES-1:0][FCW_WIDTH-1:0] car_sh_q, car_sh_d, car_act_q, car_act_d;
    logic [FCW_WIDTH-1:0]               mfcw_sh_q, mfcw_sh_d, mfcw_act_q, mfcw_act_d;
    logic [SHIFT_WIDTH-1:0]             msh_sh_q, msh_sh_d, msh_act_q, msh_act_d;
    logic [SHIFT_WIDTH-1:0]             ssh_sh_q, ssh_sh_d, ssh_act_q, ssh_act_d;
    logic [N_VOICES-1:0]                note_sh_q, note_sh_d, note_act_q, note_act_d;
    logic                               wr_fire, wr_hit, commit_fire;

    assign wr_ready    = (state_q == IDLE) & ~rst;
    assign wr_fire     = wr_valid & wr_ready;
    assign commit_fire = (state_q == PEND) & sample_tick;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (commit_req)  state_d = PEND;
            PEND:    if (sample_tick) state_d = ACK;
            ACK:     if (!commit_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ack_d = (state_d == ACK);
    end

    // Shadow bank; upper unused data bits are simply truncated away.
    always_comb begin
        car_sh_d  = car_sh_q;
        mfcw_sh_d = mfcw_sh_q;
        msh_sh_d  = msh_sh_q;
        ssh_sh_d  = ssh_sh_q;
        note_sh_d = note_sh_q;
        wr_hit    = 1'b0;
        if (wr_fire) begin
            for (int i = 0; i < N_VOICES; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    car_sh_d[i] = wr_data;
                    wr_hit      = 1'b1;
                end
            end
            if (wr_addr == ADDR_W'(N_VOICES)) begin
                mfcw_sh_d = wr_data;
                wr_hit    = 1'b1;
            end
            if (wr_addr == ADDR_W'(N_VOICES + 1)) begin
                msh_sh_d = wr_data[SHIFT_WIDTH-1:0];
                wr_hit   = 1'b1;
            end
            if (wr_addr == ADDR_W'(N_VOICES + 2)) begin
                ssh_sh_d = wr_data[SHIFT_WIDTH-1:0];
                wr_hit   = 1'b1;
            end
            if (wr_addr == ADDR_W'(N_VOICES + 3)) begin
                note_sh_d = wr_data[N_VOICES-1:0];
                wr_hit    = 1'b1;
            end
        end
        wr_err_d = wr_err_q | (wr_fire & ~wr_hit);
    end

    // Atomic transfer: every active field moves on the same PEND tick edge.
    always_comb begin
        car_act_d  = car_act_q;
        mfcw_act_d = mfcw_act_q;
        msh_act_d  = msh_act_q;
        ssh_act_d  = ssh_act_q;
        note_act_d = note_act_q;
        if (commit_fire) begin
            car_act_d  = car_sh_q;
            mfcw_act_d = mfcw_sh_q;
            msh_act_d  = msh_sh_q;
            ssh_act_d  = ssh_sh_q;
            note_act_d = note_sh_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            wr_err_q   <= 1'b0;
            car_sh_q   <= '0;
            mfcw_sh_q  <= '0;
            msh_sh_q   <= '0;
            ssh_sh_q   <= '0;
            note_sh_q  <= '0;
            car_act_q  <= '0;
            mfcw_act_q <= '0;
            msh_act_q  <= '0;
            ssh_act_q  <= '0;
            note_act_q <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            wr_err_q   <= wr_err_d;
            car_sh_q   <= car_sh_d;
            mfcw_sh_q  <= mfcw_sh_d;
            msh_sh_q   <= msh_sh_d;
            ssh_sh_q   <= ssh_sh_d;
            note_sh_q  <= note_sh_d;
            car_act_q  <= car_act_d;
            mfcw_act_q <= mfcw_act_d;
            msh_act_q  <= msh_act_d;
            ssh_act_q  <= ssh_act_d;
            note_act_q <= note_act_d;
        end
    end

    assign commit_ack   = ack_q;
    assign wr_err       = wr_err_q;
    assign carrier_fcws = car_act_q;
    assign mod_fcw      = mfcw_act_q;
    assign mod_shift    = msh_act_q;
    assign synth_shift  = ssh_act_q;
    assign note_en      = note_act_q;

`ifdef SYNTH_PARAM_READBACK_EN
    logic [FCW_WIDTH-1:0] rd_data_q, rd_data_d;

    // Reads see the active bank only, so they never stall and ignore the FSM.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            for (int i = 0; i < N_VOICES; i++) begin
                if (rd_addr == ADDR_W'(i)) rd_data_d = car_act_q[i];
            end
            if (rd_addr == ADDR_W'(N_VOICES))     rd_data_d = mfcw_act_q;
            if (rd_addr == ADDR_W'(N_VOICES + 1)) rd_data_d = FCW_WIDTH'(msh_act_q);
            if (rd_addr == ADDR_W'(N_VOICES + 2)) rd_data_d = FCW_WIDTH'(ssh_act_q);
            if (rd_addr == ADDR_W'(N_VOICES + 3)) rd_data_d = FCW_WIDTH'(note_act_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_synth_param_shadow.sv
// Directed bench for synth_param_shadow. It uses five voices because the default
// of four fills a 3-bit address space completely and so has no unmapped address.
module tb_synth_param_shadow;

    localparam int NV = 5;
    localparam int FW = 24;
    localparam int SW = 5;
    localparam int AW = $clog2(NV + 4);

    logic                     clk = 1'b0;
    logic                     rst, wr_valid, wr_ready, commit_req, commit_ack, sample_tick, wr_err;
    logic [AW-1:0]            wr_addr;
    logic [FW-1:0]            wr_data;
    logic [NV-1:0][FW-1:0]    carrier_fcws;
    logic [FW-1:0]            mod_fcw;
    logic [SW-1:0]            mod_shift, synth_shift;
    logic [NV-1:0]            note_en;

    int checks = 0;
    int errors = 0;

    synth_param_shadow #(.N_VOICES(NV), .FCW_WIDTH(FW), .SHIFT_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .commit_req(commit_req),
        .commit_ack(commit_ack), .sample_tick(sample_tick),
        .carrier_fcws(carrier_fcws), .mod_fcw(mod_fcw), .mod_shift(mod_shift),
        .synth_shift(synth_shift), .note_en(note_en), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst, wv;
        logic [AW-1:0] wa;
        logic [FW-1:0] wd;
        logic          req, tick;
        logic          rdy;
        logic [FW-1:0] c0, c1, mf;
        logic [SW-1:0] ms, ss;
        logic [NV-1:0] ne;
        logic          ack, err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic wv, input int wa, input logic [FW-1:0] wd,
                       input logic req, input logic tick, input logic rdy,
                       input logic [FW-1:0] c0, input logic [FW-1:0] c1, input logic [FW-1:0] mf,
                       input logic [SW-1:0] ms, input logic [SW-1:0] ss, input logic [NV-1:0] ne,
                       input logic ack, input logic err);
        vec_t v;
        v.rst = r; v.wv = wv; v.wa = AW'(wa); v.wd = wd; v.req = req; v.tick = tick;
        v.rdy = rdy; v.c0 = c0; v.c1 = c1; v.mf = mf; v.ms = ms; v.ss = ss; v.ne = ne;
        v.ack = ack; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        bit got_ack;
        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; commit_req = 1'b0; sample_tick = 1'b0;

        // r wv wa wd        req tk rdy c0        c1        mf        ms     ss     ne     ack err
        add(1,0,0,24'h0,      0,0, 0, 24'h0,     24'h0,    24'h0,    5'h0,  5'h0,  5'h00, 0,0); // 0 reset
        add(1,0,0,24'h0,      0,0, 0, 24'h0,     24'h0,    24'h0,    5'h0,  5'h0,  5'h00, 0,0);
        add(0,0,0,24'h0,      0,0, 1, 24'h0,     24'h0,    24'h0,    5'h0,  5'h0,  5'h00, 0,0);
        add(0,1,0,24'h123456, 0,0, 1, 24'h0,     24'h0,    24'h0,    5'h0,  5'h0,  5'h00, 0,0);
        add(0,1,8,24'hF,      0,0, 1, 24'h0,     24'h0,    24'h0,    5'h0,  5'h0,  5'h00, 0,0);
        for (int i = 0; i < 5; i++)                                                           // 5 ticks, no commit
            add(0,0,0,24'h0,  0,1, 1, 24'h0,     24'h0,    24'h0,    5'h0,  5'h0,  5'h00, 0,0);
        add(0,0,0,24'h0,      1,0, 1, 24'h0,     24'h0,    24'h0,    5'h0,  5'h0,  5'h00, 0,0); // 10 -> PEND
        add(0,0,0,24'h0,      1,1, 0, 24'h123456,24'h0,    24'h0,    5'h0,  5'h0,  5'h0F, 1,0); // commit
        add(0,0,0,24'h0,      1,0, 0, 24'h123456,24'h0,    24'h0,    5'h0,  5'h0,  5'h0F, 1,0);
        add(0,0,0,24'h0,      0,0, 0, 24'h123456,24'h0,    24'h0,    5'h0,  5'h0,  5'h0F, 0,0);
        add(0,0,0,24'h0,      0,0, 1, 24'h123456,24'h0,    24'h0,    5'h0,  5'h0,  5'h0F, 0,0);
        add(0,1,5,24'h00BEEF, 1,1, 1, 24'h123456,24'h0,    24'h0,    5'h0,  5'h0,  5'h0F, 0,0); // 15 req+tick+write
        add(0,0,0,24'h0,      1,0, 0, 24'h123456,24'h0,    24'h0,    5'h0,  5'h0,  5'h0F, 0,0);
        add(0,0,0,24'h0,      1,1, 0, 24'h123456,24'h0,    24'h00BEEF,5'h0, 5'h0,  5'h0F, 1,0);
        add(0,0,0,24'h0,      0,0, 0, 24'h123456,24'h0,    24'h00BEEF,5'h0, 5'h0,  5'h0F, 0,0);
        add(0,0,0,24'h0,      0,0, 1, 24'h123456,24'h0,    24'h00BEEF,5'h0, 5'h0,  5'h0F, 0,0);
        add(0,0,0,24'h0,      1,0, 1, 24'h123456,24'h0,    24'h00BEEF,5'h0, 5'h0,  5'h0F, 0,0); // 20 -> PEND
        add(0,1,1,24'hABCDEF, 1,0, 0, 24'h123456,24'h0,    24'h00BEEF,5'h0, 5'h0,  5'h0F, 0,0); // write stalls
        add(0,1,1,24'hABCDEF, 1,1, 0, 24'h123456,24'h0,    24'h00BEEF,5'h0, 5'h0,  5'h0F, 1,0);
        add(0,1,1,24'hABCDEF, 0,0, 0, 24'h123456,24'h0,    24'h00BEEF,5'h0, 5'h0,  5'h0F, 0,0);
        add(0,1,1,24'hABCDEF, 0,0, 1, 24'h123456,24'h0,    24'h00BEEF,5'h0, 5'h0,  5'h0F, 0,0); // taken
        add(0,0,0,24'h0,      1,0, 1, 24'h123456,24'h0,    24'h00BEEF,5'h0, 5'h0,  5'h0F, 0,0); // 25
        add(0,0,0,24'h0,      1,1, 0, 24'h123456,24'hABCDEF,24'h00BEEF,5'h0,5'h0,  5'h0F, 1,0);
        add(0,0,0,24'h0,      0,0, 0, 24'h123456,24'hABCDEF,24'h00BEEF,5'h0,5'h0,  5'h0F, 0,0);
        add(0,1,6,24'hFFFFE3, 0,0, 1, 24'h123456,24'hABCDEF,24'h00BEEF,5'h0,5'h0,  5'h0F, 0,0); // truncated fields
        add(0,1,7,24'h00001F, 0,0, 1, 24'h123456,24'hABCDEF,24'h00BEEF,5'h0,5'h0,  5'h0F, 0,0);
        add(0,1,8,24'hFFFFF2, 0,0, 1, 24'h123456,24'hABCDEF,24'h00BEEF,5'h0,5'h0,  5'h0F, 0,0); // 30
        add(0,0,0,24'h0,      1,0, 1, 24'h123456,24'hABCDEF,24'h00BEEF,5'h0,5'h0,  5'h0F, 0,0);
        add(0,0,0,24'h0,      1,1, 0, 24'h123456,24'hABCDEF,24'h00BEEF,5'h03,5'h1F,5'h12, 1,0);
        add(0,0,0,24'h0,      0,0, 0, 24'h123456,24'hABCDEF,24'h00BEEF,5'h03,5'h1F,5'h12, 0,0);
        add(0,1,9,24'h777777, 0,0, 1, 24'h123456,24'hABCDEF,24'h00BEEF,5'h03,5'h1F,5'h12, 0,1); // unmapped
        add(0,1,15,24'h0,     0,0, 1, 24'h123456,24'hABCDEF,24'h00BEEF,5'h03,5'h1F,5'h12, 0,1); // 35
        add(0,0,0,24'h0,      1,0, 1, 24'h123456,24'hABCDEF,24'h00BEEF,5'h03,5'h1F,5'h12, 0,1);
        add(0,0,0,24'h0,      1,1, 0, 24'h123456,24'hABCDEF,24'h00BEEF,5'h03,5'h1F,5'h12, 1,1);
        add(0,0,0,24'h0,      0,0, 0, 24'h123456,24'hABCDEF,24'h00BEEF,5'h03,5'h1F,5'h12, 0,1);
        add(0,1,0,24'h000555, 1,0, 1, 24'h123456,24'hABCDEF,24'h00BEEF,5'h03,5'h1F,5'h12, 0,1); // -> PEND
        add(1,0,0,24'h0,      1,0, 0, 24'h0,     24'h0,    24'h0,    5'h0,  5'h0,  5'h00, 0,0); // 40 rst mid-PEND
        add(0,0,0,24'h0,      0,1, 1, 24'h0,     24'h0,    24'h0,    5'h0,  5'h0,  5'h00, 0,0);
        add(0,0,0,24'h0,      0,0, 1, 24'h0,     24'h0,    24'h0,    5'h0,  5'h0,  5'h00, 0,0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            commit_req = vecs[i].req; sample_tick = vecs[i].tick;
            #1;
            chk("wr_ready", i, 64'(wr_ready), 64'(vecs[i].rdy));
            @(posedge clk); #1;
            chk("carrier0",    i, 64'(carrier_fcws[0]), 64'(vecs[i].c0));
            chk("carrier1",    i, 64'(carrier_fcws[1]), 64'(vecs[i].c1));
            chk("carrier4",    i, 64'(carrier_fcws[4]), 64'h0);
            chk("mod_fcw",     i, 64'(mod_fcw),         64'(vecs[i].mf));
            chk("mod_shift",   i, 64'(mod_shift),       64'(vecs[i].ms));
            chk("synth_shift", i, 64'(synth_shift),     64'(vecs[i].ss));
            chk("note_en",     i, 64'(note_en),         64'(vecs[i].ne));
            chk("commit_ack",  i, 64'(commit_ack),      64'(vecs[i].ack));
            chk("wr_err",      i, 64'(wr_err),          64'(vecs[i].err));
        end

        // Write and request together, ticks every third cycle; ack must arrive in bounded time.
        rst = 1'b0; wr_valid = 1'b1; wr_addr = AW'(0); wr_data = 24'h000001;
        commit_req = 1'b1; sample_tick = 1'b0;
        #1;
        chk("seq_wr_ready", 100, 64'(wr_ready), 64'h1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        got_ack = 1'b0;
        for (int cyc = 0; cyc < 20 && !got_ack; cyc++) begin
            sample_tick = (cyc % 3 == 2);
            @(posedge clk); #1;
            sample_tick = 1'b0;
            if (commit_ack) got_ack = 1'b1;
        end
        chk("seq_ack_seen", 100, 64'(got_ack), 64'h1);
        chk("seq_carrier0", 100, 64'(carrier_fcws[0]), 64'h000001);
        commit_req = 1'b0;
        @(posedge clk); #1;
        chk("seq_ack_drop", 100, 64'(commit_ack), 64'h0);
        chk("seq_ready_back", 100, 64'(wr_ready), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
